// File: rtl/if_stage_pkg.sv
// Shared IF/ID pipeline definitions: fetch FSM encoding, reset constants and the IF/ID word.
package if_stage_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_WORD_DEF = 32'h0000_0000;
    localparam logic [XLEN-1:0] WORD_MASK    = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instruction;
        logic [XLEN-1:0] pc_next;
    } ifid_word_t;

endpackage

// File: rtl/if_hold_buffer.sv
// Single-entry holding register for a fetched word that decode could not accept.
module if_hold_buffer
    import if_stage_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            unload,
    input  logic            clear,
    input  ifid_word_t      load_word,
    output logic            valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc4
);

    logic       valid_q, valid_d;
    ifid_word_t word_q, word_d;

    // Clear wins over load so a redirect never leaves a stale word behind.
    always_comb begin
        valid_d = valid_q;
        word_d  = word_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            word_d  = load_word;
        end else if (unload) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            word_q  <= '0;
        end else begin
            valid_q <= valid_d;
            word_q  <= word_d;
        end
    end

    assign valid = valid_q;
    assign instr = word_q.instruction;
    assign pc4   = word_q.pc_next;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches over req/ack and feeds the IF/ID register.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
    parameter logic [XLEN-1:0] NOP_WORD = NOP_WORD_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instruction,
    output logic [XLEN-1:0] pc_next
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic            req_q, req_d;
    ifid_word_t      out_q, out_d;

    logic            hold_valid;
    logic [XLEN-1:0] hold_instr;
    logic [XLEN-1:0] hold_pc4;
    logic            hold_load, hold_unload, hold_clear;

    logic            fetch_ack;
    logic            deliver;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] redirect_target;

    // An ack only counts against a live request, which also drops stale acks after reset.
    assign fetch_ack       = req_q & imem_ack;
    assign deliver         = we & ~hold_valid & ~redirect;
    assign pc_plus4        = pc_q + XLEN'(4);
    assign redirect_target = redirect_pc & WORD_MASK;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        addr_d      = addr_q;
        req_d       = req_q;
        out_d       = out_q;
        hold_load   = 1'b0;
        hold_unload = 1'b0;
        hold_clear  = redirect;

        case (state_q)
            ST_IDLE: begin
                if (redirect) begin
                    pc_d = redirect_target;
                end else if (!hold_valid) begin
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (fetch_ack) begin
                    if (redirect) begin
                        pc_d    = redirect_target;
                        req_d   = 1'b0;
                        state_d = ST_IDLE;
                    end else if (deliver) begin
                        pc_d   = pc_plus4;
                        addr_d = pc_plus4;
                    end else begin
                        hold_load = 1'b1;
                        pc_d      = pc_plus4;
                        req_d     = 1'b0;
                        state_d   = ST_IDLE;
                    end
                end else if (redirect) begin
                    // Memory cannot abort, so keep requesting and throw the data away.
                    pc_d    = redirect_target;
                    state_d = ST_DISCARD;
                end
            end
            ST_DISCARD: begin
                if (redirect) begin
                    pc_d = redirect_target;
                end
                if (fetch_ack) begin
                    req_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        if (we) begin
            if (redirect) begin
                out_d.instruction = NOP_WORD;
                out_d.pc_next     = '0;
            end else if (hold_valid) begin
                out_d.instruction = hold_instr;
                out_d.pc_next     = hold_pc4;
                hold_unload       = 1'b1;
            end else if (state_q == ST_REQ && fetch_ack) begin
                out_d.instruction = imem_rdata;
                out_d.pc_next     = pc_plus4;
            end else begin
                out_d.instruction = NOP_WORD;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q           <= ST_IDLE;
            pc_q              <= RESET_PC & WORD_MASK;
            addr_q            <= '0;
            req_q             <= 1'b0;
            out_q.instruction <= NOP_WORD;
            out_q.pc_next     <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            out_q   <= out_d;
        end
    end

    if_hold_buffer u_hold (
        .clk       (clk),
        .reset     (reset),
        .load      (hold_load),
        .unload    (hold_unload),
        .clear     (hold_clear),
        .load_word ('{instruction: imem_rdata, pc_next: pc_plus4}),
        .valid     (hold_valid),
        .instr     (hold_instr),
        .pc4       (hold_pc4)
    );

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instruction = out_q.instruction;
    assign pc_next     = out_q.pc_next;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: streaming, stall, redirects, wrap and reset abandonment.
module tb_if_stage;

    logic        clk;
    logic        reset;
    logic        we;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [31:0] pc_next;

    logic        ack_en;
    logic        ack_raw;
    logic        use_ovr;
    logic [31:0] ovr_data;

    int n_vec;
    int n_miss;

    // Zero-wait memory returning {C0DE, addr[15:0]} unless a specific word is forced.
    assign imem_ack   = ack_raw | (ack_en & imem_req);
    assign imem_rdata = use_ovr ? ovr_data : {16'hC0DE, imem_addr[15:0]};

    if_stage dut (
        .clk         (clk),
        .reset       (reset),
        .we          (we),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instruction (instruction),
        .pc_next     (pc_next)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic r, input logic [31:0] a,
                              input logic [31:0] i, input logic [31:0] p);
        check({tag, ".req"},   32'(imem_req), 32'(r));
        check({tag, ".addr"},  imem_addr, a);
        check({tag, ".instr"}, instruction, i);
        check({tag, ".pcn"},   pc_next, p);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec       = 0;
        n_miss      = 0;
        reset       = 1'b0;
        we          = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        ack_en      = 1'b0;
        ack_raw     = 1'b0;
        use_ovr     = 1'b0;
        ovr_data    = 32'h0;

        step(); step();
        expect_out("rst", 1'b0, 32'h0, 32'h0, 32'h0);

        reset  = 1'b1;
        ack_en = 1'b1;
        step(); expect_out("s1", 1'b1, 32'h0,  32'h0,         32'h0);
        step(); expect_out("s2", 1'b1, 32'h4,  32'hC0DE_0000, 32'h4);
        step(); expect_out("s3", 1'b1, 32'h8,  32'hC0DE_0004, 32'h8);
        step(); expect_out("s4", 1'b1, 32'hC,  32'hC0DE_0008, 32'hC);
        step(); expect_out("s5", 1'b1, 32'h10, 32'hC0DE_000C, 32'h10);

        // Decode stalls while the word at 0x10 returns
        we       = 1'b0;
        use_ovr  = 1'b1;
        ovr_data = 32'hAAAA_0001;
        step(); expect_out("stall1", 1'b0, 32'h10, 32'hC0DE_000C, 32'h10);
        use_ovr = 1'b0;
        step(); expect_out("stall2", 1'b0, 32'h10, 32'hC0DE_000C, 32'h10);
        step(); expect_out("stall3", 1'b0, 32'h10, 32'hC0DE_000C, 32'h10);
        we = 1'b1;
        step(); expect_out("unhold", 1'b0, 32'h10, 32'hAAAA_0001, 32'h14);
        step(); expect_out("refetch", 1'b1, 32'h14, 32'h0, 32'h14);
        step(); expect_out("s11", 1'b1, 32'h18, 32'hC0DE_0014, 32'h18);
        step(); expect_out("s12", 1'b1, 32'h1C, 32'hC0DE_0018, 32'h1C);
        step(); expect_out("s13", 1'b1, 32'h20, 32'hC0DE_001C, 32'h20);

        // Redirect to 0x400 while 0x20 is still waiting for ack
        ack_en      = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h400;
        step(); expect_out("disc1", 1'b1, 32'h20, 32'h0, 32'h0);
        redirect = 1'b0;
        step(); expect_out("disc2", 1'b1, 32'h20, 32'h0, 32'h0);
        ack_en   = 1'b1;
        use_ovr  = 1'b1;
        ovr_data = 32'hBAD0_0020;
        step(); expect_out("disc_ack", 1'b0, 32'h20, 32'h0, 32'h0);
        use_ovr = 1'b0;
        step(); expect_out("tgt_req", 1'b1, 32'h400, 32'h0, 32'h0);
        step(); expect_out("tgt_word", 1'b1, 32'h404, 32'hC0DE_0400, 32'h404);

        // Get a fresh request to 0x40, then redirect in its ack cycle
        ack_en      = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        step(); expect_out("r40_a", 1'b1, 32'h404, 32'h0, 32'h0);
        redirect = 1'b0;
        ack_en   = 1'b1;
        step(); expect_out("r40_b", 1'b0, 32'h404, 32'h0, 32'h0);
        step(); expect_out("r40_c", 1'b1, 32'h40, 32'h0, 32'h0);
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        step(); expect_out("ack_redir", 1'b0, 32'h40, 32'h0, 32'h0);
        redirect = 1'b0;
        step(); expect_out("lat_n2", 1'b1, 32'h200, 32'h0, 32'h0);

        // PC wrap and redirect target alignment
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step(); expect_out("wrap_a", 1'b0, 32'h200, 32'h0, 32'h0);
        redirect = 1'b0;
        step(); expect_out("wrap_b", 1'b1, 32'hFFFF_FFFC, 32'h0, 32'h0);
        step(); expect_out("wrap_c", 1'b1, 32'h0, 32'hC0DE_FFFC, 32'h0);
        redirect    = 1'b1;
        redirect_pc = 32'h103;
        step(); expect_out("align_a", 1'b0, 32'h0, 32'h0, 32'h0);
        redirect = 1'b0;
        step(); expect_out("align_b", 1'b1, 32'h100, 32'h0, 32'h0);
        step(); expect_out("align_c", 1'b1, 32'h104, 32'hC0DE_0100, 32'h104);

        // Reset in the middle of an outstanding request, then a stale ack
        ack_en = 1'b0;
        step(); expect_out("bubble", 1'b1, 32'h104, 32'h0, 32'h104);
        reset = 1'b0;
        #1;
        expect_out("rst_mid", 1'b0, 32'h0, 32'h0, 32'h0);
        step();
        reset    = 1'b1;
        ack_raw  = 1'b1;
        use_ovr  = 1'b1;
        ovr_data = 32'hDEAD_BEEF;
        step(); expect_out("stale1", 1'b1, 32'h0, 32'h0, 32'h0);
        ack_raw = 1'b0;
        use_ovr = 1'b0;
        step(); expect_out("stale2", 1'b1, 32'h0, 32'h0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage. It is the producer side of the IF/ID interface whose consumer is the decode stage.
- Owns the PC register and issues word reads to instruction memory over a req/ack handshake.
- Absorbs decode back-pressure (we low) in a one-entry hold buffer.
- Delivers registered instruction and pc_next to decode; on a taken branch or jump it is redirected to a new PC.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address loaded on reset.
- NOP_WORD, 32'h0000_0000, instruction word driven when a bubble is inserted (sll $0,$0,0).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- we  in  1  decode stage accepts a new IF/ID word this cycle.
- redirect  in  1  taken branch, jump or exception redirect.
- redirect_pc  in  32  new fetch address; bits [1:0] ignored and forced to 00.
- imem_req  out  1  read request, registered.
- imem_addr  out  32  word address of the request, registered; bits [1:0] always 00.
- imem_ack  in  1  read data valid; meaningful only while imem_req=1.
- imem_rdata  in  32  instruction word, sampled in the cycle where imem_req & imem_ack.
- instruction  out  32  IF/ID instruction register.
- pc_next  out  32  IF/ID register: fetch address of instruction + 4.

Behaviour:
- Reset (reset=0, asynchronous):
  - pc=RESET_PC, state=IDLE, imem_req=0, imem_addr=0.
  - hold buffer empty.
  - instruction=NOP_WORD, pc_next=0.
- State IDLE:
  - If hold buffer empty and redirect=0: next cycle imem_req=1, imem_addr=pc, go to REQ.
  - If redirect=1: pc<=redirect_pc; stay in IDLE.
- State REQ: imem_req and imem_addr held stable until imem_ack.
  - ack=1, redirect=0, word goes to output (we=1 and hold empty): instruction<=imem_rdata, pc_next<=pc+4, pc<=pc+4. Stay in REQ with imem_addr<=pc+4 (back-to-back, one word per cycle at zero-wait memory).
  - ack=1, redirect=0, cannot deliver: word and pc+4 go into the hold buffer, pc<=pc+4, imem_req<=0, go to IDLE.
  - ack=1, redirect=1: word dropped, pc<=redirect_pc, imem_req<=0, go to IDLE.
  - ack=0, redirect=1: pc<=redirect_pc, go to DISCARD. The request stays asserted, because the memory cannot abort it.
- State DISCARD:
  - Wait for ack and drop the data, then imem_req<=0 and go to IDLE.
  - A further redirect while in DISCARD only updates pc.
- Output register: updates only when we=1, otherwise holds.
  - Priority 1, redirect=1: instruction<=NOP_WORD, pc_next<=0, hold buffer cleared.
  - Priority 2, hold buffer valid: output the held word and held pc+4, then clear the hold buffer.
  - Priority 3, REQ with ack: output rdata as above.
  - Priority 4, otherwise (bubble): instruction<=NOP_WORD, pc_next unchanged.
- Redirect with we=0: the hold buffer is still cleared; the output register is left for decode's own flush to squash.
- Hold full and we=0: no new request is issued; at most one word is ever held.
- Latency: redirect in cycle N → request to redirect_pc visible in cycle N+2 when nothing is outstanding.
- Arithmetic: pc increment is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0.
- Reset during REQ or DISCARD: the outstanding request is abandoned. A stale ack arriving after reset release is ignored, because it is only honoured while imem_req=1.

Decomposition:
- Shared pipeline package holds:
  - state encoding IDLE/REQ/DISCARD (2-bit);
  - NOP_WORD constant;
  - RESET_PC default;
  - the IF/ID word struct {instruction, pc_next} used by both this stage and the decode stage.
- One sub-module: if_hold_buffer.
  - Single-entry register with load, unload and clear.
  - Outputs valid, instr, pc4.
  - Clear takes priority over load.

Test Plan:
- Reset release with RESET_PC=0, zero-wait memory (ack same cycle as req), we=1: imem_addr sequence 0,4,8; instruction tracks rdata one cycle later; pc_next=4,8,12.
- Stall: we=0 for 3 cycles while ack returns word 0xAAAA_0001 at addr 0x10. Required:
  - word held and imem_req=0 during the stall;
  - on we=1, instruction=0xAAAA_0001 and pc_next=0x14;
  - next request is to addr 0x14.
- Redirect to 0x400 while a request to 0x20 is waiting 2 cycles for ack:
  - DISCARD entered and the 0x20 data is never output;
  - next imem_addr=0x400;
  - instruction=NOP_WORD until the 0x400 word arrives.
- Redirect in the same cycle as ack (addr 0x40): the word is dropped, instruction=NOP_WORD and pc_next=0, and the next request is to the target.
- Wrap: pc=0xFFFF_FFFC fetched → pc_next=0x0 and next imem_addr=0x0. redirect_pc=0x103 → imem_addr=0x100.
- Assert reset mid-REQ, then pulse imem_ack after release: all outputs at reset values, and the ack is ignored.
